// File: rtl/gamepad_pkg.sv
// Shared definitions for the SNES-style pad poller: button bit positions, FSM states, default timing.
// Button positions follow the existing decoder: the first bit on the wire (B) is the MSB.
package gamepad_pkg;

    localparam int BTN_B      = 11;
    localparam int BTN_Y      = 10;
    localparam int BTN_SELECT = 9;
    localparam int BTN_START  = 8;
    localparam int BTN_UP     = 7;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_A      = 3;
    localparam int BTN_X      = 2;
    localparam int BTN_L      = 1;
    localparam int BTN_R      = 0;

    // Defaults give ~12 us latch and ~6 us clock phases at 25 MHz
    localparam int DEF_BIT_WIDTH    = 12;
    localparam int DEF_LATCH_CYCLES = 300;
    localparam int DEF_HALF_PERIOD  = 150;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        HIGH,
        LOW,
        DONE
    } poll_state_t;

endpackage

// File: rtl/gamepad_poll_controller_sync_2ff.sv
// Two-flop synchronizer for one asynchronous input, with a configurable reset value; 2 clk latency.
// No handshake: the output simply follows the input two cycles late.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/gamepad_poll_controller.sv
// SNES pad poll sequencer: drives latch/clock, samples the serial line, registers the button word and press events.
// buttons_valid arrives LATCH_CYCLES+(2*BIT_WIDTH-1)*HALF_PERIOD+1 clk after an accepted frame_start; requests while busy are dropped.
module gamepad_poll_controller
    import gamepad_pkg::*;
#(
    parameter int BIT_WIDTH    = DEF_BIT_WIDTH,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter int HALF_PERIOD  = DEF_HALF_PERIOD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 frame_start,
    input  logic                 pad_data,
    output logic                 pad_latch,
    output logic                 pad_clk,
    output logic [BIT_WIDTH-1:0] buttons,
    output logic                 buttons_valid,
    output logic [BIT_WIDTH-1:0] pressed_evt,
    output logic                 busy
);

    localparam int CNT_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

    localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BIT_WIDTH - 1);

    poll_state_t            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [BIT_WIDTH-1:0]   shift_q, shift_d;
    logic [BIT_WIDTH-1:0]   buttons_q, buttons_d;
    logic [BIT_WIDTH-1:0]   pressed_evt_q, pressed_evt_d;
    logic                   buttons_valid_q, buttons_valid_d;
    logic                   pad_latch_q, pad_latch_d;
    logic                   pad_clk_q, pad_clk_d;
    logic                   busy_q, busy_d;
    logic                   pad_data_s;

    // Line idles high (released) so reset must not look like a press
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_pad_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pad_data),
        .q     (pad_data_s)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        buttons_d       = buttons_q;
        pressed_evt_d   = '0;
        buttons_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_start && enable) begin
                    state_d   = LATCH;
                    cnt_d     = LATCH_LOAD;
                    bit_idx_d = '0;
                end
            end
            LATCH: begin
                if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = HALF_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HIGH: begin
                // Sample at the end of the high phase so the synchronizer has settled on the new bit
                if (cnt_q == '0) begin
                    shift_d = {shift_q[BIT_WIDTH-2:0], ~pad_data_s};
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOW;
                        cnt_d   = HALF_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    state_d   = HIGH;
                    cnt_d     = HALF_LOAD;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                buttons_d       = shift_q;
                pressed_evt_d   = shift_q & ~buttons_q;
                buttons_valid_d = 1'b1;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pad strobes are registered off the next state so they line up with state_q
        pad_latch_d = (state_d == LATCH);
        pad_clk_d   = (state_d != LOW);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            buttons_q       <= '0;
            pressed_evt_q   <= '0;
            buttons_valid_q <= 1'b0;
            pad_latch_q     <= 1'b0;
            pad_clk_q       <= 1'b1;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            buttons_q       <= buttons_d;
            pressed_evt_q   <= pressed_evt_d;
            buttons_valid_q <= buttons_valid_d;
            pad_latch_q     <= pad_latch_d;
            pad_clk_q       <= pad_clk_d;
            busy_q          <= busy_d;
        end
    end

    assign pad_latch     = pad_latch_q;
    assign pad_clk       = pad_clk_q;
    assign buttons       = buttons_q;
    assign buttons_valid = buttons_valid_q;
    assign pressed_evt   = pressed_evt_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_gamepad_poll_controller.sv
// Directed bench for gamepad_poll_controller with a behavioural SNES pad on the serial bus.
// Poll vectors come from a table; reset, enable and request-collision cases are hand sequences.
module tb_gamepad_poll_controller;
    import gamepad_pkg::*;

    localparam int BW      = 12;
    localparam int EXP_LAT = 4 + (2 * BW - 1) * 3 + 1;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          frame_start;
    logic          pad_data;
    logic          pad_latch;
    logic          pad_clk;
    logic [BW-1:0] buttons;
    logic          buttons_valid;
    logic [BW-1:0] pressed_evt;
    logic          busy;

    gamepad_poll_controller #(
        .BIT_WIDTH    (BW),
        .LATCH_CYCLES (4),
        .HALF_PERIOD  (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .frame_start   (frame_start),
        .pad_data      (pad_data),
        .pad_latch     (pad_latch),
        .pad_clk       (pad_clk),
        .buttons       (buttons),
        .buttons_valid (buttons_valid),
        .pressed_evt   (pressed_evt),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pad model: latch loads the pressed pattern, each pad_clk rise presents the next bit, wire is active-low
    logic [BW-1:0] pad_pattern;
    logic [BW-1:0] pad_sr;
    initial begin
        pad_pattern = '0;
        pad_sr      = '0;
    end
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) pad_sr = pad_pattern;
        else           pad_sr = {pad_sr[BW-2:0], 1'b0};
    end
    assign pad_data = ~pad_sr[BW-1];

    int n_checks;
    int n_fail;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-poll observations
    int            lat, latch_cnt, low_pulses, bad_low, bad_high, valid_cnt, stray_pe, busy_low;
    logic [BW-1:0] cap_b, cap_pe;

    // Issues frame_start (sampled at edge 0) and watches 150 cycles; extra requests at offsets fs1/fs2
    task automatic do_poll(input logic [BW-1:0] pat, input int fs1, input int fs2);
        int   run;
        logic prev_clk;
        bit   seen_low;
        pad_pattern = pat;
        lat = -1; latch_cnt = 0; low_pulses = 0; bad_low = 0; bad_high = 0;
        valid_cnt = 0; stray_pe = 0; busy_low = 0;
        cap_b = '0; cap_pe = '0;
        run = 0; prev_clk = 1'b1; seen_low = 1'b0;
        frame_start = 1'b1;
        tick();
        for (int n = 0; n < 150; n++) begin
            if (n > 0) tick();
            if (pad_latch) latch_cnt++;
            if (pad_clk != prev_clk) begin
                if (!prev_clk) begin
                    low_pulses++;
                    if (run != 3) bad_low++;
                    seen_low = 1'b1;
                end else if (seen_low && run != 3) begin
                    bad_high++;
                end
                run = 0;
            end
            run++;
            prev_clk = pad_clk;
            if (n < EXP_LAT && !busy) busy_low++;
            if (buttons_valid) begin
                valid_cnt++;
                if (lat < 0) begin
                    lat    = n;
                    cap_b  = buttons;
                    cap_pe = pressed_evt;
                end
            end else if (pressed_evt != '0) begin
                stray_pe++;
            end
            frame_start = (n == fs1) || (n == fs2);
        end
        frame_start = 1'b0;
    endtask

    typedef struct {
        logic [BW-1:0] pat;
        logic [BW-1:0] exp_b;
        logic [BW-1:0] exp_pe;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int idle_latch, idle_busy, idle_valid;

        vecs[0] = '{pat: 12'((1 << BTN_B) | (1 << BTN_R)), exp_b: 12'h801, exp_pe: 12'h801};
        vecs[1] = '{pat: 12'h803, exp_b: 12'h803, exp_pe: 12'h002};
        vecs[2] = '{pat: 12'h803, exp_b: 12'h803, exp_pe: 12'h000};
        vecs[3] = '{pat: 12'h000, exp_b: 12'h000, exp_pe: 12'h000};
        vecs[4] = '{pat: 12'hFFF, exp_b: 12'hFFF, exp_pe: 12'hFFF};
        vecs[5] = '{pat: 12'h0A5, exp_b: 12'h0A5, exp_pe: 12'h000};
        vecs[6] = '{pat: 12'h5A0, exp_b: 12'h5A0, exp_pe: 12'h500};

        n_checks = 0;
        n_fail   = 0;
        reset       = 1'b1;
        enable      = 1'b1;
        frame_start = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_pad_latch", int'(pad_latch), 0);
        check("rst_pad_clk", int'(pad_clk), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_buttons", int'(buttons), 0);
        check("rst_valid", int'(buttons_valid), 0);
        check("rst_pressed", int'(pressed_evt), 0);

        idle_latch = 0; idle_busy = 0; idle_valid = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (pad_latch) idle_latch++;
            if (busy) idle_busy++;
            if (buttons_valid) idle_valid++;
        end
        check("idle_latch_cycles", idle_latch, 0);
        check("idle_busy_cycles", idle_busy, 0);
        check("idle_valid_cycles", idle_valid, 0);

        for (int v = 0; v < 7; v++) begin
            do_poll(vecs[v].pat, -1, -1);
            check($sformatf("v%0d_latency", v), lat, EXP_LAT);
            check($sformatf("v%0d_buttons", v), int'(cap_b), int'(vecs[v].exp_b));
            check($sformatf("v%0d_pressed", v), int'(cap_pe), int'(vecs[v].exp_pe));
            check($sformatf("v%0d_latch_width", v), latch_cnt, 4);
            check($sformatf("v%0d_low_pulses", v), low_pulses, BW - 1);
            check($sformatf("v%0d_bad_low_len", v), bad_low, 0);
            check($sformatf("v%0d_bad_high_len", v), bad_high, 0);
            check($sformatf("v%0d_valid_pulses", v), valid_cnt, 1);
            check($sformatf("v%0d_stray_pressed", v), stray_pe, 0);
            check($sformatf("v%0d_busy_gap", v), busy_low, 0);
            check($sformatf("v%0d_idle_after", v), int'(busy), 0);
        end

        // Requests mid-poll and during DONE must not start a second poll
        do_poll(12'h5A0, 10, EXP_LAT - 1);
        check("dup_latch_width", latch_cnt, 4);
        check("dup_valid_pulses", valid_cnt, 1);
        check("dup_latency", lat, EXP_LAT);
        check("dup_busy_gap", busy_low, 0);
        check("dup_buttons", int'(cap_b), 12'h5A0);
        check("dup_pressed", int'(cap_pe), 0);
        check("dup_idle_after", int'(busy), 0);

        // Polling disabled: request is ignored
        enable      = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        idle_latch = 0; idle_busy = 0;
        for (int i = 0; i < 100; i++) begin
            if (pad_latch) idle_latch++;
            if (busy) idle_busy++;
            tick();
        end
        check("dis_latch_cycles", idle_latch, 0);
        check("dis_busy_cycles", idle_busy, 0);
        enable = 1'b1;

        // Reset 30 cycles into a poll
        pad_pattern = 12'hFFF;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (30) tick();
        check("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_pad_latch", int'(pad_latch), 0);
        check("mid_rst_pad_clk", int'(pad_clk), 1);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_buttons", int'(buttons), 0);
        check("mid_rst_valid", int'(buttons_valid), 0);
        idle_valid = 0; idle_busy = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (buttons_valid) idle_valid++;
            if (busy) idle_busy++;
        end
        check("post_rst_valid", idle_valid, 0);
        check("post_rst_busy", idle_busy, 0);

        do_poll(12'h801, -1, -1);
        check("after_rst_latency", lat, EXP_LAT);
        check("after_rst_buttons", int'(cap_b), 12'h801);
        check("after_rst_pressed", int'(cap_pe), 12'h801);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gamepad_poll_controller.md
Name: gamepad_poll_controller

Overview:
Host-side sequencer for the SNES-style game controller PMOD. It generates the latch and clock waveforms toward the pad once per frame, or once per request, and samples the serial data line. It delivers a registered 12-bit button word in the same bit order as the existing decoder, plus one-cycle press-event flags. It sits between the VGA frame timing (frame_start from the sync generator) and game logic, and replaces passive sniffing when the design owns the pad bus.

Parameters:
BIT_WIDTH, 12, number of serial bits read per poll.
LATCH_CYCLES, 300, clk cycles pad_latch is held high (≈12 µs at 25 MHz); must be ≥1.
HALF_PERIOD, 150, clk cycles per pad_clk phase (≈6 µs at 25 MHz); must be ≥3 to cover synchronizer latency.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = polling permitted; sampled only in IDLE
frame_start  in  1  one-cycle poll request (e.g. vsync start)
pad_data  in  1  serial data from pad; active-low (0 = pressed); asynchronous
pad_latch  out  1  latch strobe to pad, active-high
pad_clk  out  1  shift clock to pad; idles high
buttons  out  BIT_WIDTH  last complete sample, 1 = pressed; bit[BIT_WIDTH-1] = first bit read (B), order {b,y,select,start,up,down,left,right,a,x,l,r}
buttons_valid  out  1  one-cycle pulse when buttons updates
pressed_evt  out  BIT_WIDTH  one-cycle pulse, coincident with buttons_valid, per button newly pressed
busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset are fixed: a single clock, clk; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: pad_latch=0, pad_clk=1, buttons=0, buttons_valid=0, pressed_evt=0, busy=0, state=IDLE, synchronizer=2'b11 (released).
- pad_data passes through a 2-flop synchronizer. Only the synchronized value (pad_data_s) is used.
- FSM:
  - IDLE: pad_latch=0, pad_clk=1. If frame_start && enable, go to LATCH with cnt=LATCH_CYCLES-1 and bit_idx=0.
  - LATCH: pad_latch=1 for exactly LATCH_CYCLES cycles, then go to HIGH with cnt=HALF_PERIOD-1.
  - HIGH: pad_clk=1 for HALF_PERIOD cycles. On the last cycle, shift={shift[BIT_WIDTH-2:0], ~pad_data_s}. If bit_idx==BIT_WIDTH-1, go to DONE; otherwise go to LOW.
  - LOW: pad_clk=0 for HALF_PERIOD cycles, then go to HIGH with bit_idx+1.
  - DONE (1 cycle): buttons<=shift; pressed_evt<=shift & ~buttons (old value); buttons_valid<=1; then IDLE.
- Latency: buttons_valid rises LATCH_CYCLES + (2·BIT_WIDTH−1)·HALF_PERIOD + 1 cycles after the cycle in which frame_start is accepted.
- pressed_evt and buttons_valid are 0 in every cycle other than the one following DONE.
- frame_start while busy is ignored; it is not queued.
- frame_start in the same cycle as DONE is ignored.
- enable deasserted mid-poll does not abort the poll; the poll completes.
- Reset mid-poll: the next cycle matches the reset values, and the partial shift is discarded.
- Unplugged pad (pull-up, line stays 1) reads all zeros and is valid; this is not an error.
- Counters are sized $clog2(max(LATCH_CYCLES, HALF_PERIOD)) and do not wrap within a poll.
- bit_idx is sized $clog2(BIT_WIDTH).

Decomposition:
- Package gamepad_pkg:
  - button index localparams (BTN_B=11 … BTN_R=0)
  - FSM state enum {IDLE, LATCH, HIGH, LOW, DONE}
  - default timing constants
- One sub-module: sync_2ff (parameterised reset value), used for pad_data.

Test Plan:
- Use LATCH_CYCLES=4, HALF_PERIOD=3 for all scenarios.
- Reset then idle: pad_latch=0, pad_clk=1, busy=0, buttons=0. No frame_start → no pad_latch pulse for 200 cycles.
- Pad model drives pattern 12'b1000_0000_0001 (B and R pressed, active-low on the wire, bit changes on pad_clk rising edge) → buttons_valid exactly 74 cycles after frame_start; buttons=12'h801; pressed_evt=12'h801.
- Second poll with 12'h803 → pressed_evt=12'h002 and buttons=12'h803. A third identical poll → pressed_evt=0.
- Waveform checks:
  - pad_latch high exactly 4 cycles.
  - 11 pad_clk low pulses of 3 cycles each.
  - pad_clk high between pulses for 3 cycles.
- frame_start pulsed at cycles +10 and +73 of a poll → single poll only; busy stays high throughout; returns to IDLE.
- enable=0 with frame_start → no activity.
- Reset asserted at cycle +30 of a poll → next cycle: pad_latch=0, pad_clk=1, busy=0, buttons=0, no buttons_valid. A new poll then completes normally.
